// File: rtl/port_rr_arbiter_if.sv
// Handshake bundle between the ingress ports and the write-path arbiter.
// Latency: none; this is wiring only.
// Backpressure: ports hold i_req until their o_resp bit; o_port_ready marks arbitration slots.
//
// master: ingress side, which drives requests, end-of-packet and the mode.
// slave : arbiter side, which drives grant, select, ready and timeout.
interface port_rr_arbiter_if #(
  parameter int PORTNUM = 16
);
  localparam int SELW = $clog2(PORTNUM);

  logic [PORTNUM-1:0] i_req;
  logic               i_eop;
  logic               i_mode;
  logic               o_port_ready;
  logic [PORTNUM-1:0] o_resp;
  logic [PORTNUM-1:0] o_nresp;
  logic [PORTNUM-1:0] o_gnt;
  logic [SELW-1:0]    o_sel;
  logic               o_timeout;

  modport master (
    output i_req, i_eop, i_mode,
    input  o_port_ready, o_resp, o_nresp, o_gnt, o_sel, o_timeout
  );

  modport slave (
    input  i_req, i_eop, i_mode,
    output o_port_ready, o_resp, o_nresp, o_gnt, o_sel, o_timeout
  );
endinterface

// File: rtl/port_rr_arbiter.sv
// Grants one of PORTNUM ingress ports the shared write path for one packet (fixed or round-robin).
// Latency: request sampled at edge N shows o_resp/o_gnt after edge N; release after the i_eop edge.
// Backpressure: requests are ignored while BUSY; a watchdog force-releases a grant stuck without i_eop.
//
// Ports: i_clk, i_rst_n (synchronous, active low) plus the slave side of port_rr_arbiter_if:
//   i_req/i_eop/i_mode in; o_port_ready (state decode), o_resp/o_nresp (one-cycle pulses),
//   o_gnt (held one-hot), o_sel (winner index), o_timeout (one-cycle watchdog pulse) out.
module port_rr_arbiter #(
  parameter int PORTNUM = 16,
  parameter int TIMEOUT = 1024
) (
  input logic              i_clk,
  input logic              i_rst_n,
  port_rr_arbiter_if.slave bus
);
  localparam int SELW = $clog2(PORTNUM);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [SELW-1:0]    ptr_q, ptr_d;
  logic [PORTNUM-1:0] resp_q, resp_d;
  logic [PORTNUM-1:0] nresp_q, nresp_d;
  logic [PORTNUM-1:0] gnt_q, gnt_d;
  logic [SELW-1:0]    sel_q, sel_d;
  logic               timeout_q, timeout_d;

  logic [SELW-1:0]    win_idx;
  logic [PORTNUM-1:0] win_oh;
  logic               grant;
  logic               wd_fire;
  logic               rel_busy;

  // Winner search: scan upward from the rotating pointer in round-robin mode,
  // from port 0 in fixed mode; the index wraps past PORTNUM-1 back to 0.
  always_comb begin
    int  base;
    int  idx;
    logic found;
    base    = bus.i_mode ? int'(ptr_q) : 0;
    idx     = 0;
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < PORTNUM; k++) begin
      idx = base + k;
      if (idx >= PORTNUM) idx = idx - PORTNUM;
      if (!found && bus.i_req[idx]) begin
        found   = 1'b1;
        win_idx = SELW'(idx);
      end
    end
  end

  assign win_oh   = PORTNUM'(1) << win_idx;
  assign grant    = (state_q == IDLE) && (|bus.i_req);
  // i_eop and the watchdog both end a packet; i_eop takes precedence for o_timeout.
  assign rel_busy = bus.i_eop || wd_fire;

  // Watchdog: counts BUSY cycles from 0; fires on the TIMEOUT-th BUSY cycle.
  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int CNTW = $clog2(TIMEOUT + 1);
      logic [CNTW-1:0] cnt_q;

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          cnt_q <= '0;
        end else if (state_q == BUSY && !rel_busy) begin
          cnt_q <= cnt_q + 1'b1;
        end else begin
          cnt_q <= '0;
        end
      end

      assign wd_fire = (state_q == BUSY) && (cnt_q == CNTW'(TIMEOUT - 1));
    end else begin : g_no_wd
      assign wd_fire = 1'b0;
    end
  endgenerate

  // State register, rotating pointer and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      resp_q    <= '0;
      nresp_q   <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      resp_q    <= resp_d;
      nresp_q   <= nresp_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state. The pointer advances on every grant, fixed mode included,
  // so a later switch to round-robin continues from the last winner.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = BUSY;
          ptr_d   = (win_idx == SELW'(PORTNUM - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      BUSY: begin
        if (rel_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    resp_d    = '0;
    nresp_d   = '0;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (grant) begin
          resp_d  = win_oh;
          nresp_d = bus.i_req & ~win_oh;
          gnt_d   = win_oh;
          sel_d   = win_idx;
        end
      end
      BUSY: begin
        if (rel_busy) begin
          gnt_d     = '0;
          timeout_d = wd_fire && !bus.i_eop;
        end
      end
      default: gnt_d = '0;
    endcase
  end

  assign bus.o_port_ready = (state_q == IDLE);
  assign bus.o_resp       = resp_q;
  assign bus.o_nresp      = nresp_q;
  assign bus.o_gnt        = gnt_q;
  assign bus.o_sel        = sel_q;
  assign bus.o_timeout    = timeout_q;
endmodule

// File: tb/tb_port_rr_arbiter.sv
// Bench for port_rr_arbiter: directed scenarios plus randomized packets against a queue scoreboard.
// Latency: expectations carry the cycle number at which the DUT must present them.
// Backpressure: the driver only issues a new request once its model says the arbiter is idle.
module tb_port_rr_arbiter;
  localparam int N  = 16;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  port_rr_arbiter_if #(.PORTNUM(N)) bus ();

  port_rr_arbiter #(.PORTNUM(N), .TIMEOUT(TO)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int          cyc;
    logic [15:0] resp;
    logic [15:0] nresp;
    int          sel;
  } gexp_t;

  typedef struct {
    int cyc;
    bit to;
    int sel;
  } rexp_t;

  gexp_t grant_q[$];
  rexp_t rel_q[$];
  int    rr_ptr = 0;   // reference round-robin pointer

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arbitration: first requesting port at or after the start index, wrapping.
  function automatic int pick(input logic [15:0] req, input bit mode);
    int start;
    start = mode ? rr_ptr : 0;
    for (int k = 0; k < N; k++)
      if (req[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  // ---------------- monitor ----------------
  logic        prev_ready = 1'b1;
  logic [15:0] cur_gnt = '0;

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (bus.o_resp != 0 || (prev_ready && !bus.o_port_ready)) begin
        if (grant_q.size() == 0) begin
          check("unexpected_grant", bus.o_resp, 32'h0);
        end else begin
          gexp_t e;
          e = grant_q.pop_front();
          check("grant_cycle", cyc, e.cyc);
          check("resp", bus.o_resp, e.resp);
          check("nresp", bus.o_nresp, e.nresp);
          check("gnt_on_grant", bus.o_gnt, e.resp);
          check("sel_on_grant", bus.o_sel, e.sel);
          check("ready_on_grant", bus.o_port_ready, 1'b0);
          cur_gnt = e.resp;
        end
      end else if (!bus.o_port_ready) begin
        check("gnt_hold", bus.o_gnt, cur_gnt);
        check("resp_busy", bus.o_resp | bus.o_nresp, 32'h0);
      end

      if (bus.o_timeout || (!prev_ready && bus.o_port_ready)) begin
        if (rel_q.size() == 0) begin
          check("unexpected_release", bus.o_timeout, 1'b0);
        end else begin
          rexp_t r;
          r = rel_q.pop_front();
          check("release_cycle", cyc, r.cyc);
          check("timeout", bus.o_timeout, r.to);
          check("gnt_after_release", bus.o_gnt, 32'h0);
          check("sel_after_release", bus.o_sel, r.sel);
          check("ready_after_release", bus.o_port_ready, 1'b1);
        end
      end else if (bus.o_port_ready && bus.o_resp == 0) begin
        check("idle_gnt", bus.o_gnt, 32'h0);
        check("idle_nresp", bus.o_nresp, 32'h0);
      end
    end
    prev_ready = bus.o_port_ready;
  end

  // ---------------- driver ----------------
  // Called at a negedge while the arbiter is idle. The packet ends with i_eop on
  // BUSY cycle `hold` (1-based); if hold exceeds TO the watchdog releases it.
  task automatic packet(input logic [15:0] req, input bit mode, input int hold);
    int w;
    bus.i_req  = req;
    bus.i_mode = mode;
    bus.i_eop  = 1'($urandom_range(0, 1));   // i_eop while idle must be ignored
    if (req == 0) begin
      @(negedge clk);
      bus.i_eop = 1'b0;
      return;
    end
    w = pick(req, mode);
    grant_q.push_back('{cyc + 1, 16'h1 << w, req & ~(16'h1 << w), w});
    rr_ptr = (w + 1) % N;
    @(negedge clk);
    for (int b = 1; b <= TO; b++) begin
      bus.i_req  = 16'($urandom);             // request churn during BUSY is ignored
      bus.i_mode = 1'($urandom_range(0, 1));
      if (b == hold) begin
        bus.i_eop = 1'b1;
        rel_q.push_back('{cyc + 1, 1'b0, w});
        @(negedge clk);
        break;
      end
      bus.i_eop = 1'b0;
      if (b == TO) rel_q.push_back('{cyc + 1, 1'b1, w});
      @(negedge clk);
    end
    bus.i_eop = 1'b0;
    bus.i_req = '0;
  endtask

  initial begin
    logic [15:0] rq;
    rst_n      = 1'b0;
    bus.i_req  = '0;
    bus.i_eop  = 1'b0;
    bus.i_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Reset state with no requests for five cycles.
    repeat (5) @(negedge clk);
    check("rst_ready", bus.o_port_ready, 1'b1);
    check("rst_resp", bus.o_resp, 32'h0);
    check("rst_gnt", bus.o_gnt, 32'h0);
    check("rst_sel", bus.o_sel, 32'h0);
    check("rst_timeout", bus.o_timeout, 1'b0);

    // Reset in the middle of BUSY with port 4 granted.
    bus.i_req  = 16'h0010;
    bus.i_mode = 1'b0;
    grant_q.push_back('{cyc + 1, 16'h0010, 16'h0000, 4});
    rr_ptr = 5;
    @(negedge clk);
    bus.i_req = '0;
    @(negedge clk);
    check("mid_gnt", bus.o_gnt, 32'h0010);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_ready", bus.o_port_ready, 1'b1);
    check("mrst_resp", bus.o_resp, 32'h0);
    check("mrst_nresp", bus.o_nresp, 32'h0);
    check("mrst_gnt", bus.o_gnt, 32'h0);
    check("mrst_sel", bus.o_sel, 32'h0);
    check("mrst_timeout", bus.o_timeout, 1'b0);
    rr_ptr = 0;
    mon_en = 1'b1;
    packet(16'hFFFF, 1'b1, 2);               // pointer restarted at 0 -> port 0

    // Round-robin with 8014 held: 2, 4, 15, then wrap to 2.
    for (int i = 0; i < 4; i++) packet(16'h8014, 1'b1, 1 + i);

    // Fixed priority: lowest index wins regardless of pointer.
    packet(16'h8014, 1'b0, 3);
    packet(16'h8000, 1'b0, 1);

    // Watchdog: no i_eop -> timeout; i_eop on the last BUSY cycle -> no timeout.
    packet(16'h0001, 1'b0, 100);
    packet(16'h0001, 1'b0, TO);

    // Mode flips during BUSY; the next arbitration uses the mode driven while idle.
    packet(16'h8001, 1'b1, 3);
    packet(16'h8001, 1'b0, 3);
    packet(16'h8001, 1'b1, 2);

    // Randomized packets and idle gaps.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0:       rq = 16'h1 << $urandom_range(0, 15);
        1:       rq = '0;
        default: rq = 16'($urandom);
      endcase
      packet(rq, 1'($urandom_range(0, 1)), $urandom_range(1, TO + 3));
    end

    repeat (4) @(negedge clk);
    check("grant_q_drained", grant_q.size(), 32'h0);
    check("rel_q_drained", rel_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
